elevator: RTL and testbench

ELEVATOR -- requirements
Module: elevator

---
 rtl/elevator.sv | 142 ++++++++++++++
 tb/tb_elevator.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/elevator.sv
// Single-car collective (SCAN) elevator controller: latches hall/car calls,
// moves one floor every TIME cycles, holds the door open for TIME cycles.
module elevator #(
  parameter int TIME = 4,
  parameter int n    = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [n-1:0] button_out,
  input  logic [n-1:0] button_in,
  output logic         open,
  output logic         close_n,
  output logic         up,
  output logic         down,
  output logic [n-1:0] current_floor
);

  typedef enum logic [1:0] {S_IDLE, S_MOVE_UP, S_MOVE_DOWN, S_DOOR_OPEN} state_t;
  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;

  localparam logic [7:0]   T_LAST = 8'(TIME - 1);
  localparam logic [n-1:0] ONE    = {{(n-1){1'b0}}, 1'b1};

  state_t       r_state, w_state_nxt;
  dir_t         r_dir, w_dir_nxt;
  logic [7:0]   r_timer, w_timer_nxt;
  logic [n-1:0] r_floor, w_floor_nxt;
  logic [n-1:0] r_req, w_clear;
  logic [n-1:0] w_buttons, w_req_all, w_next_floor;
  logic         w_here, w_any_above, w_any_below, w_beyond;
  logic         r_open, r_up, r_down;
  logic         w_open_nxt, w_up_nxt, w_down_nxt;

  // Masks of floors strictly above / below a one-hot position.
  function automatic logic [n-1:0] above_mask(input logic [n-1:0] f);
    return ~((f << 1) - ONE);
  endfunction

  function automatic logic [n-1:0] below_mask(input logic [n-1:0] f);
    return f - ONE;
  endfunction

  assign w_buttons    = button_out | button_in;
  assign w_req_all    = r_req | w_buttons;
  assign w_here       = |(w_req_all & r_floor);
  assign w_any_above  = |(w_req_all & above_mask(r_floor));
  assign w_any_below  = |(w_req_all & below_mask(r_floor));
  assign w_next_floor = (r_state == S_MOVE_UP) ? (r_floor << 1) : (r_floor >> 1);
  assign w_beyond     = (r_state == S_MOVE_UP) ? |(w_req_all & above_mask(w_next_floor))
                                               : |(w_req_all & below_mask(w_next_floor));

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values present before the edge.
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_dir   <= DIR_UP;
      r_timer <= '0;
      r_floor <= ONE;
      r_req   <= '0;
      r_open  <= 1'b0;
      r_up    <= 1'b0;
      r_down  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_dir   <= w_dir_nxt;
      r_timer <= w_timer_nxt;
      r_floor <= w_floor_nxt;
      r_req   <= w_req_all & ~w_clear;
      r_open  <= w_open_nxt;
      r_up    <= w_up_nxt;
      r_down  <= w_down_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    w_state_nxt = r_state;
    w_dir_nxt   = r_dir;
    w_timer_nxt = r_timer;
    w_floor_nxt = r_floor;
    w_clear     = '0;
    case (r_state)
      S_IDLE: begin
        w_timer_nxt = '0;
        if (w_here) begin
          w_state_nxt = S_DOOR_OPEN;
          w_clear     = r_floor;
        end else if (w_any_above && (!w_any_below || r_dir == DIR_UP)) begin
          w_state_nxt = S_MOVE_UP;
          w_dir_nxt   = DIR_UP;
        end else if (w_any_below) begin
          w_state_nxt = S_MOVE_DOWN;
          w_dir_nxt   = DIR_DOWN;
        end
      end
      S_MOVE_UP, S_MOVE_DOWN: begin
        if (r_timer == T_LAST) begin
          w_timer_nxt = '0;
          w_floor_nxt = w_next_floor;
          // Arrival decision is made on the shift edge, keeping floor-to-floor at TIME.
          if (|(w_req_all & w_next_floor)) begin
            w_state_nxt = S_DOOR_OPEN;
            w_clear     = w_next_floor;
          end else if (!w_beyond) begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_timer_nxt = r_timer + 8'd1;
        end
      end
      S_DOOR_OPEN: begin
        w_clear = r_floor;
        if (|(w_buttons & r_floor)) begin
          w_timer_nxt = '0;
        end else if (r_timer == T_LAST) begin
          w_timer_nxt = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_timer_nxt = r_timer + 8'd1;
        end
      end
    endcase
  end

  // Output logic, decoded from the next state and registered above
  always_comb begin
    w_open_nxt = (w_state_nxt == S_DOOR_OPEN);
    w_up_nxt   = (w_state_nxt == S_MOVE_UP);
    w_down_nxt = (w_state_nxt == S_MOVE_DOWN);
  end

  assign open          = r_open;
  assign close_n       = r_open;
  assign up            = r_up;
  assign down          = r_down;
  assign current_floor = r_floor;

endmodule

// File: tb/tb_elevator.sv
// Directed testbench for the elevator controller (TIME = 4, n = 5) with
// hand-derived per-cycle output traces.
module tb_elevator;

  localparam int TIME = 4;
  localparam int N    = 5;

  localparam int K_IDLE = 0;
  localparam int K_UP   = 1;
  localparam int K_DN   = 2;
  localparam int K_OPEN = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] button_out = '0;
  logic [N-1:0] button_in = '0;
  logic         open, close_n, up, down;
  logic [N-1:0] current_floor;

  int vectors = 0;
  int miscompares = 0;
  logic [8:0] exp_q[$];

  elevator #(.TIME(TIME), .n(N)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .button_out   (button_out),
    .button_in    (button_in),
    .open         (open),
    .close_n      (close_n),
    .up           (up),
    .down         (down),
    .current_floor(current_floor)
  );

  always #5 clk = ~clk;

  // Expected packing: {open, close_n, up, down, current_floor}
  function automatic logic [8:0] exp_vec(input int kind, input int fl);
    logic [N-1:0] oh;
    oh = '0;
    oh[fl] = 1'b1;
    case (kind)
      K_UP:    return {4'b0010, oh};
      K_DN:    return {4'b0001, oh};
      K_OPEN:  return {4'b1100, oh};
      default: return {4'b0000, oh};
    endcase
  endfunction

  function automatic logic [8:0] obs();
    return {open, close_n, up, down, current_floor};
  endfunction

  task automatic push(input int kind, input int fl, input int cnt);
    repeat (cnt) exp_q.push_back(exp_vec(kind, fl));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    button_in = '0;
    button_out = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Reset with buttons held; then idle forever at floor 0.
  task automatic test_reset();
    exp_q.delete();
    push(K_IDLE, 0, 14);
    rst_n = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      rst_n      = (i >= 2);
      button_in  = (i < 2) ? 5'b11111 : 5'b00000;
      button_out = (i < 2) ? 5'b10101 : 5'b00000;
      tick();
      if (obs() !== exp_q[i]) begin
        miscompares++;
        $display("FAIL reset step %0d: got %b want %b", i, obs(), exp_q[i]);
      end
      vectors++;
    end
  endtask

  // Request at the current floor from IDLE opens the door next cycle.
  task automatic test_same_floor();
    apply_reset();
    exp_q.delete();
    push(K_OPEN, 0, 4);
    push(K_IDLE, 0, 4);
    for (int i = 0; i < exp_q.size(); i++) begin
      button_out = (i == 0) ? 5'b00001 : 5'b00000;
      tick();
      if (obs() !== exp_q[i]) begin
        miscompares++;
        $display("FAIL same_floor step %0d: got %b want %b", i, obs(), exp_q[i]);
      end
      vectors++;
    end
  endtask

  // Pressing the current floor while open restarts the timer and is not latched.
  task automatic test_door_restart();
    apply_reset();
    exp_q.delete();
    push(K_OPEN, 0, 6);
    push(K_IDLE, 0, 5);
    for (int i = 0; i < exp_q.size(); i++) begin
      button_out = (i == 0 || i == 2) ? 5'b00001 : 5'b00000;
      tick();
      if (obs() !== exp_q[i]) begin
        miscompares++;
        $display("FAIL door_restart step %0d: got %b want %b", i, obs(), exp_q[i]);
      end
      vectors++;
    end
  endtask

  // Car call two floors up: TIME cycles per floor, TIME cycles open.
  task automatic test_single_up();
    apply_reset();
    exp_q.delete();
    push(K_UP, 0, 4);
    push(K_UP, 1, 4);
    push(K_OPEN, 2, 4);
    push(K_IDLE, 2, 4);
    for (int i = 0; i < exp_q.size(); i++) begin
      button_in = (i == 0) ? 5'b00100 : 5'b00000;
      tick();
      if (obs() !== exp_q[i]) begin
        miscompares++;
        $display("FAIL single_up step %0d: got %b want %b", i, obs(), exp_q[i]);
      end
      vectors++;
    end
  endtask

  // Going up to 4, a call behind at floor 0 waits for reversal.
  task automatic test_scan();
    apply_reset();
    exp_q.delete();
    push(K_UP, 0, 4);
    push(K_UP, 1, 4);
    push(K_UP, 2, 4);
    push(K_UP, 3, 4);
    push(K_OPEN, 4, 4);
    push(K_IDLE, 4, 1);
    push(K_DN, 4, 4);
    push(K_DN, 3, 4);
    push(K_DN, 2, 4);
    push(K_DN, 1, 4);
    push(K_OPEN, 0, 4);
    push(K_IDLE, 0, 3);
    for (int i = 0; i < exp_q.size(); i++) begin
      button_in  = (i == 0)  ? 5'b10000 : 5'b00000;
      button_out = (i == 10) ? 5'b00001 : 5'b00000;
      tick();
      if (obs() !== exp_q[i]) begin
        miscompares++;
        $display("FAIL scan step %0d: got %b want %b", i, obs(), exp_q[i]);
      end
      vectors++;
    end
  endtask

  // With calls both above and below, IDLE keeps the last travel direction.
  task automatic test_dir_pref();
    apply_reset();
    exp_q.delete();
    push(K_UP, 0, 4);
    push(K_UP, 1, 4);
    push(K_UP, 2, 4);
    push(K_OPEN, 3, 4);
    push(K_IDLE, 3, 1);
    push(K_DN, 3, 4);
    push(K_DN, 2, 4);
    push(K_OPEN, 1, 4);
    push(K_IDLE, 1, 1);
    push(K_DN, 1, 4);
    push(K_OPEN, 0, 4);
    push(K_IDLE, 0, 1);
    push(K_UP, 0, 4);
    push(K_UP, 1, 4);
    push(K_UP, 2, 4);
    push(K_UP, 3, 4);
    push(K_OPEN, 4, 4);
    push(K_IDLE, 4, 2);
    for (int i = 0; i < exp_q.size(); i++) begin
      case (i)
        0:       button_in = 5'b01000;
        17:      button_in = 5'b00010;
        30:      button_in = 5'b10001;
        default: button_in = 5'b00000;
      endcase
      tick();
      if (obs() !== exp_q[i]) begin
        miscompares++;
        $display("FAIL dir_pref step %0d: got %b want %b", i, obs(), exp_q[i]);
      end
      vectors++;
    end
  endtask

  // Reset between floors 2 and 3 returns to floor 0; buttons during reset are dropped.
  task automatic test_reset_mid_move();
    apply_reset();
    exp_q.delete();
    push(K_UP, 0, 4);
    push(K_UP, 1, 4);
    push(K_UP, 2, 2);
    push(K_IDLE, 0, 6);
    for (int i = 0; i < exp_q.size(); i++) begin
      rst_n     = (i != 10);
      button_in = (i == 0) ? 5'b01000 : (i == 10) ? 5'b10000 : 5'b00000;
      tick();
      if (obs() !== exp_q[i]) begin
        miscompares++;
        $display("FAIL reset_mid_move step %0d: got %b want %b", i, obs(), exp_q[i]);
      end
      vectors++;
    end
    rst_n = 1'b1;
  endtask

  // All car buttons at floor 0: stops at every floor in order.
  task automatic test_all_floors();
    apply_reset();
    exp_q.delete();
    push(K_OPEN, 0, 4);
    for (int f = 1; f < N; f++) begin
      push(K_IDLE, f - 1, 1);
      push(K_UP, f - 1, 4);
      push(K_OPEN, f, 4);
    end
    push(K_IDLE, 4, 4);
    for (int i = 0; i < exp_q.size(); i++) begin
      button_in = (i == 0) ? 5'b11111 : 5'b00000;
      tick();
      if (obs() !== exp_q[i]) begin
        miscompares++;
        $display("FAIL all_floors step %0d: got %b want %b", i, obs(), exp_q[i]);
      end
      vectors++;
    end
  endtask

  initial begin
    test_reset();
    test_same_floor();
    test_door_restart();
    test_single_up();
    test_scan();
    test_dir_pref();
    test_reset_mid_move();
    test_all_floors();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
